// File: rtl/arb_rr8.sv
// Eight-way round-robin arbiter with a per-grant hold quantum.
// The registered grant index drives a one-hot grant decode, so at most one grant line is active.
module arb_rr8 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] nxt_start;

    // First asserted request found scanning start, start+1, ... start+7 (mod 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        nxt_start = gnt_idx_q + 3'd1;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = GRANT;
                    gnt_idx_d = rr_pick(req, ptr_q);
                    cnt_d     = 8'd0;
                end
            end
            GRANT: begin
                // Release and expiry share one path: searching from gnt_idx+1 only
                // lands back on the current holder when nobody else is asking.
                if (!req[gnt_idx_q] || (cnt_q == CNT_LAST)) begin
                    ptr_d = nxt_start;
                    cnt_d = 8'd0;
                    if (|req) begin
                        gnt_idx_d = rr_pick(req, nxt_start);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_idx_q <= 3'd0;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = (state_q == GRANT) ? (8'b1 << gnt_idx_q) : 8'h00;
    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_arb_rr8.sv
// Directed bench for arb_rr8: four instances with HOLD_MAX = 8, 2, 4 and 1 share one clock and reset.
module tb_arb_rr8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_a, req_b, req_c, req_d;
    logic [7:0] gnt_a, gnt_b, gnt_c, gnt_d;
    logic [2:0] idx_a, idx_b, idx_c, idx_d;
    logic       busy_a, busy_b, busy_c, busy_d;

    int n_checks = 0;
    int n_fail   = 0;

    arb_rr8 #(.HOLD_MAX(8)) dut_a (.clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a), .busy(busy_a));
    arb_rr8 #(.HOLD_MAX(2)) dut_b (.clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b), .busy(busy_b));
    arb_rr8 #(.HOLD_MAX(4)) dut_c (.clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c), .busy(busy_c));
    arb_rr8 #(.HOLD_MAX(1)) dut_d (.clk(clk), .rst_n(rst_n), .req(req_d), .gnt(gnt_d), .gnt_idx(idx_d), .busy(busy_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] oh(input int i);
        return 8'b1 << i;
    endfunction

    int exp_c[12] = '{2, 2, 2, 0, 0, 0, 0, 1, 1, 1, 1, 2};

    initial begin
        rst_n = 1'b0;
        req_a = 8'h00;
        req_b = 8'h00;
        req_c = 8'h00;
        req_d = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("rst_gnt_a", gnt_a, 8'h00);
        chk("rst_busy_a", {7'd0, busy_a}, 8'h00);
        chk("rst_idx_a", {5'd0, idx_a}, 8'h00);
        chk("rst_gnt_d", gnt_d, 8'h00);

        // Single requester 4 keeps the grant across quantum recycles
        req_a = 8'h10;
        step();
        chk("single_gnt", gnt_a, 8'h10);
        chk("single_idx", {5'd0, idx_a}, 8'h04);
        chk("single_busy", {7'd0, busy_a}, 8'h01);
        for (int i = 0; i < 24; i++) begin
            step();
            chk("single_hold", gnt_a, 8'h10);
        end
        req_a = 8'h00;
        step();
        chk("drop_gnt", gnt_a, 8'h00);
        chk("drop_busy", {7'd0, busy_a}, 8'h00);
        chk("drop_idx_held", {5'd0, idx_a}, 8'h04);

        // Early release on 6 wraps through 7 to 0 without a bubble
        req_a = 8'h40;
        step();
        chk("wrap_first", {5'd0, idx_a}, 8'h06);
        req_a = 8'h41;
        step();
        chk("wrap_hold6", gnt_a, 8'h40);
        req_a = 8'h01;
        step();
        chk("wrap_gnt0", gnt_a, 8'h01);
        chk("wrap_busy", {7'd0, busy_a}, 8'h01);
        chk("wrap_ptr", {5'd0, dut_a.ptr_q}, 8'h07);
        req_a = 8'h00;

        // Full contention, HOLD_MAX = 2: 0,0,1,1,...,7,7,0
        req_b = 8'hFF;
        for (int k = 0; k < 17; k++) begin
            step();
            chk("full_gnt", gnt_b, oh((k / 2) % 8));
            chk("full_busy", {7'd0, busy_b}, 8'h01);
        end

        // Skip idle requester 1, then late join of 1 while 2 holds
        req_c = 8'h05;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("skip_hold0", gnt_c, 8'h01);
        end
        step();
        chk("skip_to2", gnt_c, 8'h04);
        req_c = 8'h07;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("join_order", gnt_c, oh(exp_c[k]));
        end

        // HOLD_MAX = 1 alternates 0 and 7 every cycle
        req_d = 8'h81;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("alt_idx", {5'd0, idx_d}, (k % 2 == 1) ? 8'h07 : 8'h00);
            chk("alt_busy", {7'd0, busy_d}, 8'h01);
        end

        // Asynchronous reset mid-grant clears grants without a clock edge
        req_c = 8'hFF;
        step();
        chk("pre_rst_busy_c", {7'd0, busy_c}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt_b", gnt_b, 8'h00);
        chk("arst_gnt_c", gnt_c, 8'h00);
        chk("arst_busy_c", {7'd0, busy_c}, 8'h00);
        chk("arst_gnt_d", gnt_d, 8'h00);
        req_b = 8'h00;
        req_c = 8'h00;
        req_d = 8'h00;
        step();
        rst_n = 1'b1;
        chk("arst_idx_b", {5'd0, idx_b}, 8'h00);
        chk("arst_idx_c", {5'd0, idx_c}, 8'h00);
        chk("arst_ptr_c", {5'd0, dut_c.ptr_q}, 8'h00);
        step();
        chk("post_rst_gnt_c", gnt_c, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
